// File: rtl/rpi_dac_wr_if.sv
// Host/DAC bundle for the rpi_dac_wr write path.
// Ports: host side carries wr, data_in, ack and start. DAC side carries dac_data and dac_valid.
//   Status outputs are level, full, underrun and led. master = host/bench, slave = rpi_dac_wr.
interface rpi_dac_wr_if #(
  parameter int DW = 12,
  parameter int AW = 10
);
  logic          wr;
  logic [DW-1:0] data_in;
  logic          ack;
  logic          start;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic [AW:0]   level;
  logic          full;
  logic          underrun;
  logic [7:0]    led;

  modport master (
    output wr, data_in, start,
    input  ack, dac_data, dac_valid, level, full, underrun, led
  );

  modport slave (
    input  wr, data_in, start,
    output ack, dac_data, dac_valid, level, full, underrun, led
  );
endinterface

// File: rtl/rpi_dac_wr.sv
// Host-to-DAC ring buffer: the host writes samples over the async wr/ack handshake, and the block plays them out every RATE_DIV clocks.
// Latency: ack rises SYNC_STAGES+2 clocks after wr. dac_data and dac_valid follow the sample tick by one clock.
// Backpressure: a full buffer stalls the host by holding ack low until a pop frees space. An empty buffer on a tick counts an underrun.
// Ports: clk, rst (async, active-high), and bus (rpi_dac_wr_if.slave).
module rpi_dac_wr #(
  parameter int DW          = 12,
  parameter int AW          = 10,
  parameter int RATE_DIV    = 100,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  rpi_dac_wr_if.slave bus
);

  localparam int DEPTH = 1 << AW;
  localparam int DIVW  = $clog2(RATE_DIV);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_ACK  = 2'd2;

  localparam logic [0:0] P_IDLE = 1'b0;
  localparam logic [0:0] P_RUN  = 1'b1;

  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] start_sync;
  logic                   wr_s;
  logic                   start_s;

  logic [1:0]      w_state;
  logic [0:0]      p_state;
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [DIVW-1:0] div;
  logic [DW-1:0]   mem [DEPTH];

  logic        cap;
  logic        tick;
  logic        pop;
  logic        empty_tick;
  logic [AW:0] level_nxt;

  // Two-flop (or deeper) synchronisers on the host's asynchronous controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sync    <= '0;
      start_sync <= '0;
    end else begin
      wr_sync    <= {wr_sync[SYNC_STAGES-2:0], bus.wr};
      start_sync <= {start_sync[SYNC_STAGES-2:0], bus.start};
    end
  end

  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign start_s = start_sync[SYNC_STAGES-1];

  // Capture uses the registered full flag. A pop therefore frees space for a stalled write only on the following cycle.
  assign cap        = !bus.full && ((w_state == W_IDLE && wr_s) || (w_state == W_WAIT));
  assign tick       = (p_state == P_RUN) && (div == DIVW'(RATE_DIV - 1));
  assign pop        = tick && (bus.level != '0);
  assign empty_tick = tick && (bus.level == '0);

  always_comb begin
    level_nxt = bus.level;
    if (cap && !pop) begin
      level_nxt = bus.level + 1'b1;
    end else if (pop && !cap) begin
      level_nxt = bus.level - 1'b1;
    end
  end

  // Write FSM. ack is set one cycle after the capture edge and drops on the same edge that returns to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      bus.ack <= 1'b0;
      wp      <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_s) begin
            w_state <= bus.full ? W_WAIT : W_ACK;
          end
        end
        W_WAIT: begin
          if (!bus.full) begin
            w_state <= W_ACK;
          end
        end
        W_ACK: begin
          if (!wr_s) begin
            bus.ack <= 1'b0;
            w_state <= W_IDLE;
          end else begin
            bus.ack <= 1'b1;
          end
        end
        default: begin
          bus.ack <= 1'b0;
          w_state <= W_IDLE;
        end
      endcase
      if (cap) begin
        wp <= wp + 1'b1;
      end
    end
  end

  // Sample storage has no reset. Its contents are don't-care until they are written.
  always_ff @(posedge clk) begin
    if (cap) begin
      mem[wp] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.level <= '0;
      bus.full  <= 1'b0;
    end else begin
      bus.level <= level_nxt;
      bus.full  <= (level_nxt == (AW + 1)'(DEPTH));
    end
  end

  // Playback FSM. A tick still completes its pop even if start falls during that tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state       <= P_IDLE;
      div           <= '0;
      rp            <= '0;
      bus.dac_data  <= '0;
      bus.dac_valid <= 1'b0;
      bus.underrun  <= 1'b0;
      bus.led       <= '0;
    end else begin
      bus.dac_valid <= pop;
      if (pop) begin
        bus.dac_data <= mem[rp];
        rp           <= rp + 1'b1;
      end
      if (empty_tick) begin
        bus.underrun <= 1'b1;
        if (bus.led != 8'hFF) begin
          bus.led <= bus.led + 1'b1;
        end
      end
      case (p_state)
        P_IDLE: begin
          div <= '0;
          if (start_s) begin
            p_state <= P_RUN;
          end
        end
        default: begin
          if (!start_s) begin
            p_state <= P_IDLE;
            div     <= '0;
          end else begin
            div <= tick ? '0 : div + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpi_dac_wr.sv
module tb_rpi_dac_wr;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  rpi_dac_wr_if #(.DW(12), .AW(10)) bus ();

  rpi_dac_wr #(.DW(12), .AW(10), .RATE_DIV(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [11:0] got[$];
  int          gt[$];
  int          lvl_max = 0;
  int          vbad = 0;
  logic        prev_v = 1'b0;

  always @(negedge clk) begin
    if (bus.dac_valid === 1'b1) begin
      got.push_back(bus.dac_data);
      gt.push_back(cyc);
      if (prev_v) vbad++;
    end
    prev_v = (bus.dac_valid === 1'b1);
    if (int'(bus.level) > lvl_max) lvl_max = int'(bus.level);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [11:0] d, output bit ok);
    int n;
    ok = 1'b1;
    bus.data_in = d;
    bus.wr = 1'b1;
    n = 0;
    while (bus.ack !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (bus.ack !== 1'b1) ok = 1'b0;
    bus.wr = 1'b0;
    n = 0;
    while (bus.ack !== 1'b0 && n < 64) begin @(negedge clk); n++; end
    if (bus.ack !== 1'b0) ok = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wr = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got.delete();
    gt.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [11:0] din;
    logic [10:0] lvl;
  } vec_t;

  vec_t        vec[4];
  logic [11:0] samp[3000];

  initial begin
    bit ok;
    bit all_ok;
    int n;
    int mism;

    vec[0] = '{din: 12'h000, lvl: 11'd1};
    vec[1] = '{din: 12'h001, lvl: 11'd2};
    vec[2] = '{din: 12'h002, lvl: 11'd3};
    vec[3] = '{din: 12'h003, lvl: 11'd4};

    rst = 1'b1;
    bus.wr = 1'b0;
    bus.start = 1'b0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_dac_valid", bus.dac_valid, 0);
    chk("rst_dac_data", bus.dac_data, 0);
    chk("rst_led", bus.led, 0);
    chk("rst_underrun", bus.underrun, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write: ack latency both ways.
    bus.data_in = 12'hA5C;
    bus.wr = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ack !== 1'b1 && n < 32);
    chk("ack_rise_latency", n, 4);
    chk("single_level", bus.level, 1);
    bus.wr = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ack !== 1'b0 && n < 32);
    chk("ack_fall_within_3", (n >= 1 && n <= 3), 1);

    // Playback order from the vector table.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      host_write(vec[i].din, ok);
      chk("pb_write_ok", ok, 1);
      chk("pb_level", bus.level, vec[i].lvl);
    end
    bus.start = 1'b1;
    n = 0;
    while (got.size() < 4 && n < 200) begin @(negedge clk); n++; end
    chk("pb_count", got.size(), 4);
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("pb_data", got[i], vec[i].din);
      for (int i = 1; i < 4; i++) chk("pb_spacing", gt[i] - gt[i-1], 4);
    end
    chk("pb_level_end", bus.level, 0);
    bus.start = 1'b0;

    // Underrun on an empty buffer, then recovery.
    do_reset();
    bus.start = 1'b1;
    n = 0;
    while (bus.led !== 8'd3 && n < 100) begin @(negedge clk); n++; end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("ur_led", bus.led, 3);
    chk("ur_flag", bus.underrun, 1);
    chk("ur_no_valid", got.size(), 0);
    host_write(12'h123, ok);
    chk("ur_write_ok", ok, 1);
    bus.start = 1'b1;
    n = 0;
    while (got.size() < 1 && n < 40) begin @(negedge clk); n++; end
    chk("ur_recover_count", got.size(), 1);
    if (got.size() >= 1) chk("ur_recover_data", got[0], 12'h123);
    chk("ur_led_hold", bus.led, 3);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);

    // Reset while ack is high, with led and underrun already set.
    bus.data_in = 12'h777;
    bus.wr = 1'b1;
    n = 0;
    while (bus.ack !== 1'b1 && n < 32) begin @(negedge clk); n++; end
    chk("mid_ack_seen", bus.ack, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", bus.ack, 0);
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_valid", bus.dac_valid, 0);
    chk("mid_rst_led", bus.led, 0);
    chk("mid_rst_underrun", bus.underrun, 0);
    bus.wr = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got.delete();
    gt.delete();
    rst = 1'b0;
    all_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ack !== 1'b0 || bus.level !== '0 || bus.dac_valid !== 1'b0 || bus.led !== '0 ||
          bus.underrun !== 1'b0 || bus.full !== 1'b0 || bus.dac_data !== '0) all_ok = 1'b0;
    end
    chk("idle_after_reset", all_ok, 1);

    // Fill to capacity, then stall the extra write until a pop frees a slot.
    all_ok = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      host_write(12'((i * 3) & 12'hFFF), ok);
      if (!ok) all_ok = 1'b0;
    end
    chk("fill_writes_ok", all_ok, 1);
    chk("fill_level", bus.level, 1024);
    chk("fill_full", bus.full, 1);
    bus.data_in = 12'hABC;
    bus.wr = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.ack !== 1'b0 || bus.level !== 11'd1024) all_ok = 1'b0;
    end
    chk("stall_ack_low", all_ok, 1);
    bus.start = 1'b1;
    n = 0;
    while (bus.ack !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    chk("stall_ack_rise", bus.ack, 1);
    chk("stall_level_refull", bus.level, 1024);
    chk("stall_one_pop", got.size(), 1);
    if (got.size() >= 1) chk("stall_first_out", got[0], 12'h000);
    bus.wr = 1'b0;
    bus.start = 1'b0;

    // Long stream: pointer wrap and captures coinciding with pops.
    do_reset();
    for (int i = 0; i < 3000; i++) samp[i] = 12'((i * 13 + 5) & 12'hFFF);
    all_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      host_write(samp[i], ok);
      if (!ok) all_ok = 1'b0;
    end
    bus.start = 1'b1;
    for (int i = 1000; i < 3000; i++) begin
      host_write(samp[i], ok);
      if (!ok) all_ok = 1'b0;
    end
    chk("stream_writes_ok", all_ok, 1);
    n = 0;
    while (got.size() < 3000 && n < 8000) begin @(negedge clk); n++; end
    chk("stream_count", got.size(), 3000);
    mism = 0;
    for (int i = 0; i < 3000 && i < got.size(); i++) if (got[i] !== samp[i]) mism++;
    chk("stream_mismatches", mism, 0);
    chk("level_never_over_depth", (lvl_max <= 1024), 1);
    chk("dac_valid_one_cycle", vbad, 0);
    bus.start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpi_dac_wr.md
Name: rpi_dac_wr

Overview:
Host-to-FPGA write path, the reverse of the ADC read-out path. The Raspberry Pi pushes 12-bit samples over an asynchronous wr/ack handshake into an on-chip ring buffer. Once the host raises start, the block plays the buffer out to a DAC interface at a fixed sample rate. Buffer level and underrun status are exported, and the underrun count drives the board LEDs.

Parameters:
DW, 12, sample width in bits
AW, 10, buffer address width; DEPTH = 2**AW = 1024 entries
RATE_DIV, 100, clk cycles per output sample; must be >= 2
SYNC_STAGES, 2, flip-flop stages on the asynchronous host inputs wr and start

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
wr  input  1  host write strobe, asynchronous to clk
data_in  input  DW  host sample; host holds it stable from before wr rises until ack is seen high
ack  output  1  write acknowledge to host
start  input  1  host playback enable (level), asynchronous
dac_data  output  DW  sample to DAC
dac_valid  output  1  one-cycle strobe; dac_data is new this cycle
level  output  AW+1  buffer occupancy, 0..DEPTH
full  output  1  level == DEPTH
underrun  output  1  sticky flag: a sample tick found the buffer empty
led  output  8  underrun count, saturating at 255

Behaviour:
- Reset (async assert; release synchronous to clk). All of the following clear to 0: ack, dac_data, dac_valid, level, full, underrun, led, write pointer, read pointer, rate divider, sync flops. Both FSMs go to their IDLE state. Buffer contents are don't-care. Reset applies identically mid-operation.
- Synchronisers: wr_s and start_s are the outputs of SYNC_STAGES flops. data_in is not synchronised; the handshake guarantees it is stable when sampled.
- Write FSM states: W_IDLE, W_WAIT, W_ACK.
  - W_IDLE: when wr_s = 1 and !full, write data_in to mem[wp], increment wp (wraps at DEPTH), increment level, go to W_ACK.
  - W_IDLE: when wr_s = 1 and full, go to W_WAIT.
  - W_WAIT: ack stays 0. Capture as in W_IDLE on the first cycle with !full, then go to W_ACK. This stalls the host; no sample is dropped.
  - W_ACK: ack = 1, registered, so it first appears the cycle after capture. Hold until wr_s = 0, then ack = 0 and go to W_IDLE.
  - Exactly one capture per wr pulse.
- Playback FSM states: P_IDLE, P_RUN.
  - P_IDLE: divider held at 0. On start_s = 1, go to P_RUN.
  - P_RUN: divider counts 0..RATE_DIV-1 and wraps. Tick = divider at RATE_DIV-1.
  - On tick with level > 0: read mem[rp], increment rp (wraps), decrement level.
  - On tick with level = 0: set underrun, increment led (saturating at 255). dac_data holds its previous value and no dac_valid is issued.
  - On start_s = 0, go to P_IDLE. A read issued on the tick cycle still completes.
- Read latency: tick at cycle T; dac_data updates and dac_valid = 1 at T+1. dac_valid is exactly 1 cycle wide.
- Simultaneous capture and tick-pop in one cycle: both execute and level is unchanged. A pop frees space for a W_WAIT capture in the following cycle, not the same one.
- A pop on a full buffer and a capture on an empty buffer are both legal; full and level are registered and consistent with the pointers every cycle.
- underrun and led clear only on rst.

Test Plan:
- Reset mid-handshake: assert rst while ack = 1 -> ack, level, dac_valid and led all 0 in the same cycle. After release, wr = 0 and start = 0 keep all outputs 0.
- Single write: data_in = 12'hA5C, pulse wr -> ack rises SYNC_STAGES+2 cycles after wr; level = 1; ack falls within SYNC_STAGES+1 cycles of wr falling.
- Playback order: write 0,1,2,3, then raise start with RATE_DIV = 4 -> dac_valid every 4 cycles, dac_data = 0,1,2,3 in order; level reaches 0.
- Full stall: write 1024 samples, then a 1025th with start = 0 -> level = 1024, full = 1, ack stays 0. Raise start -> after the first pop the 1025th sample is captured, ack rises, level = 1024 again.
- Underrun: start with an empty buffer for 3 ticks -> underrun = 1, led = 3, no dac_valid. Write 12'h123 -> next tick outputs 12'h123 with dac_valid.
- Pointer wrap and simultaneous events: stream 3000 samples with a capture and a pop landing on the same cycle -> output sequence equals input sequence, no loss, level never exceeds 1024.
